// File: rtl/regfile_pkg.sv
// Shared constants and types for the multiport register file.
// Build option: define REGFILE_BYPASS_EN for same-cycle write-through forwarding.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;
  localparam int NUM_RD_DEF = 3;
  localparam int PC_IDX_DEF = 15;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

  function automatic int num_regs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/multiport_register_file_if.sv
// Decode/writeback bus of the register file: read ports, write port, issue port, scoreboard view.
// The datapath drives through the master modport; the register file uses the slave modport.
interface multiport_register_file_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);

  localparam int NUM_REGS = num_regs(ADDR_W);

  logic                     we;
  logic [ADDR_W-1:0]        wa;
  logic [DATA_W-1:0]        wd;
  logic [DATA_W-1:0]        pc_in;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic                     iss_v;
  logic [ADDR_W-1:0]        iss_a;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_REGS-1:0]      busy_vec;

  modport master (
    output we, wa, wd, pc_in, ra, iss_v, iss_a,
    input  rd, rd_busy, busy_vec
  );

  modport slave (
    input  we, wa, wd, pc_in, ra, iss_v, iss_a,
    output rd, rd_busy, busy_vec
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for RAW hazard detection: issue sets, writeback clears, set wins.
// The PC alias index is never marked busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PC_IDX = PC_IDX_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_clr_v,
  input  logic [ADDR_W-1:0]           i_clr_a,
  input  logic                        i_set_v,
  input  logic [ADDR_W-1:0]           i_set_a,
  output logic [num_regs(ADDR_W)-1:0] o_busy
);

  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  logic [num_regs(ADDR_W)-1:0] r_busy;

  // NOTE: non-blocking updates; when both hit the same bit the later
  // assignment (the set) is the one that lands, giving set-over-clear priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (i_clr_v && (i_clr_a != PC_A)) r_busy[i_clr_a] <= 1'b0;
      if (i_set_v && (i_set_a != PC_A)) r_busy[i_set_a] <= 1'b1;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/multiport_register_file.sv
// NUM_RD combinational read ports, one synchronous write port, PC alias and busy scoreboard.
// Build option: REGFILE_BYPASS_EN forwards the in-flight write to matching read ports.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int PC_IDX = PC_IDX_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  multiport_register_file_if.slave bus
);

  localparam int                NUM_REGS = num_regs(ADDR_W);
  localparam logic [ADDR_W-1:0] PC_A     = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;
  logic                w_wr_en;

  assign w_wr_en = bus.we && (bus.wa != PC_A);

  // NOTE: the data array is reset on purpose so every non-PC read is 0 during
  // and right after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_REGS; n++) r_regs[n] <= '0;
    end else if (w_wr_en) begin
      r_regs[bus.wa] <= bus.wd;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .PC_IDX (PC_IDX)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .i_clr_v (bus.we),
    .i_clr_a (bus.wa),
    .i_set_v (bus.iss_v),
    .i_set_a (bus.iss_a),
    .o_busy  (w_busy)
  );

  assign bus.busy_vec = w_busy;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;
    logic              w_rd_busy;

    assign w_ra = bus.ra[gi*ADDR_W +: ADDR_W];

    // NOTE: combinational logic uses blocking '=' with every output given a
    // default first, so no path leaves a value held and no latch is inferred.
    always_comb begin
      w_rd      = r_regs[w_ra];
      w_rd_busy = w_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_en && (bus.wa == w_ra)) begin
        w_rd      = bus.wd;
        w_rd_busy = bus.iss_v && (bus.iss_a == w_ra);
      end
`endif
      if (w_ra == PC_A) begin
        w_rd      = bus.pc_in;
        w_rd_busy = 1'b0;
      end
    end

    assign bus.rd[gi*DATA_W +: DATA_W] = w_rd;
    assign bus.rd_busy[gi]             = w_rd_busy;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file: array/scoreboard model checked every negedge,
// plus hand-computed literal checks for reset, PC alias, write, scoreboard and mid-op reset.
module tb_multiport_register_file;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 3;
  localparam int NREG = 16;
  localparam int PCI = 15;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  bit   run_cmp;

  multiport_register_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  multiport_register_file #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR),
    .PC_IDX (PCI)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what each register holds and which are awaiting writeback.
  word_t       m_regs [NREG];
  logic [15:0] m_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NREG; n++) m_regs[n] <= '0;
      m_busy <= '0;
    end else begin
      if (bus.we && bus.wa != 4'(PCI)) begin
        m_regs[bus.wa] <= bus.wd;
        if (!(bus.iss_v && bus.iss_a == bus.wa)) m_busy[bus.wa] <= 1'b0;
      end
      if (bus.iss_v && bus.iss_a != 4'(PCI)) m_busy[bus.iss_a] <= 1'b1;
    end
  end

  function automatic word_t model_rd(input reg_idx_t idx);
    if (idx == 4'(PCI)) return bus.pc_in;
`ifdef REGFILE_BYPASS_EN
    if (bus.we && bus.wa == idx) return bus.wd;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic model_rd_busy(input reg_idx_t idx);
    if (idx == 4'(PCI)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (bus.we && bus.wa == idx) return bus.iss_v && (bus.iss_a == idx);
`endif
    return m_busy[idx];
  endfunction

  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      for (int p = 0; p < NR; p++) begin
        reg_idx_t idx;
        idx = bus.ra[p*AW +: AW];
        check("cmp_rd", bus.rd[p*DW +: DW], model_rd(idx));
        check("cmp_rd_busy", 32'(bus.rd_busy[p]), 32'(model_rd_busy(idx)));
      end
      check("cmp_busy_vec", 32'(bus.busy_vec), 32'(m_busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input reg_idx_t a0, input reg_idx_t a1, input reg_idx_t a2);
    bus.ra = {a2, a1, a0};
  endtask

  task automatic idle();
    bus.we    = 1'b0;
    bus.iss_v = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    run_cmp  = 1'b0;
    rst      = 1'b1;
    bus.we   = 1'b0;
    bus.wa   = '0;
    bus.wd   = '0;
    bus.pc_in = '0;
    bus.ra   = '0;
    bus.iss_v = 1'b0;
    bus.iss_a = '0;

    // 1. Reset
    #6 rst = 1'b0;
    run_cmp = 1'b1;
    for (int i = 0; i < 15; i++) begin
      set_ra(4'(i), 4'(i), 4'(i));
      #1;
      check("reset_rd0", bus.rd[31:0], 32'h0);
      check("reset_rd2", bus.rd[95:64], 32'h0);
    end
    check("reset_busy_vec", 32'(bus.busy_vec), 32'h0);
    check("reset_rd_busy", 32'(bus.rd_busy), 32'h0);

    // 2. PC alias, and writes to the PC index are dropped
    tick();
    set_ra(4'd15, 4'd0, 4'd0);
    bus.pc_in = 32'h8;
    #1;
    check("pc_alias", bus.rd[31:0], 32'h8);
    bus.we = 1'b1; bus.wa = 4'd15; bus.wd = 32'h5;
    bus.iss_v = 1'b1; bus.iss_a = 4'd15;
    #1;
    check("pc_write_same_cycle", bus.rd[31:0], 32'h8);
    tick();
    idle();
    #1;
    check("pc_write_dropped", bus.rd[31:0], 32'h8);
    check("pc_never_busy", 32'(bus.busy_vec), 32'h0);
    check("pc_rd_busy", 32'(bus.rd_busy[0]), 32'h0);

    // 3. Write then read on all ports
    set_ra(4'd3, 4'd3, 4'd3);
    bus.we = 1'b1; bus.wa = 4'd3; bus.wd = 32'hDEAD_BEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("wr_same_cycle_bypass", bus.rd[31:0], 32'hDEAD_BEEF);
`else
    check("wr_same_cycle_old", bus.rd[31:0], 32'h0);
`endif
    tick();
    idle();
    #1;
    check("wr_rd0", bus.rd[31:0], 32'hDEAD_BEEF);
    check("wr_rd1", bus.rd[63:32], 32'hDEAD_BEEF);
    check("wr_rd2", bus.rd[95:64], 32'hDEAD_BEEF);
    check("wr_nonbusy_stays_0", 32'(bus.busy_vec), 32'h0);

    // 4. Scoreboard set then clear
    set_ra(4'd4, 4'd3, 4'd15);
    bus.iss_v = 1'b1; bus.iss_a = 4'd4;
    tick();
    idle();
    #1;
    check("sb_set", 32'(bus.busy_vec), 32'h0010);
    check("sb_rd_busy_set", 32'(bus.rd_busy), 32'b001);
    bus.we = 1'b1; bus.wa = 4'd4; bus.wd = 32'h0000_0044;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("sb_wb_cycle_busy", 32'(bus.rd_busy[0]), 32'h0);
`else
    check("sb_wb_cycle_busy", 32'(bus.rd_busy[0]), 32'h1);
`endif
    tick();
    idle();
    #1;
    check("sb_clear", 32'(bus.busy_vec), 32'h0);
    check("sb_clear_data", bus.rd[31:0], 32'h0000_0044);

    // 5. Set/clear collision on the same index: set wins
    set_ra(4'd6, 4'd4, 4'd3);
    bus.iss_v = 1'b1; bus.iss_a = 4'd6;
    bus.we = 1'b1; bus.wa = 4'd6; bus.wd = 32'h0000_0066;
    tick();
    idle();
    #1;
    check("collide_data", bus.rd[31:0], 32'h0000_0066);
    check("collide_busy", 32'(bus.busy_vec), 32'h0040);
    check("collide_rd_busy", 32'(bus.rd_busy), 32'b001);

    // Multiple ports on distinct and shared addresses
    set_ra(4'd3, 4'd6, 4'd3);
    #1;
    check("mix_rd1", bus.rd[63:32], 32'h0000_0066);
    check("mix_rd2", bus.rd[95:64], 32'hDEAD_BEEF);

    // 6. Mid-operation reset
    bus.iss_v = 1'b1; bus.iss_a = 4'd2;
    bus.we = 1'b1; bus.wa = 4'd9; bus.wd = 32'h1;
    tick();
    bus.we = 1'b0;
    bus.iss_a = 4'd7;
    tick();
    idle();
    set_ra(4'd9, 4'd7, 4'd2);
    #1;
    check("pre_rst_busy", 32'(bus.busy_vec), 32'h00C4);
    check("pre_rst_r9", bus.rd[31:0], 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy_vec", 32'(bus.busy_vec), 32'h0);
    check("midrst_r9", bus.rd[31:0], 32'h0);
    check("midrst_rd_busy", 32'(bus.rd_busy), 32'h0);
    bus.we = 1'b1; bus.wa = 4'd5; bus.wd = 32'h5555_5555;
    bus.iss_v = 1'b1; bus.iss_a = 4'd5;
    tick();
    rst = 1'b0;
    idle();
    set_ra(4'd5, 4'd3, 4'd6);
    #1;
    check("rst_write_lost", bus.rd[31:0], 32'h0);
    check("rst_r3", bus.rd[63:32], 32'h0);
    check("rst_busy_lost", 32'(bus.busy_vec), 32'h0);
    tick();
    tick();

    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
